// File: rtl/pgm_tb_sched.sv
// pgm_tb_sched: token-bucket packet scheduler for a packet generator.
//
// A run starts from a CTRL write and lasts until TARGET packets have been
// granted or an abort is written. Each grant spends req_len bytes of tokens.
// The bucket refills by RATE bytes per cycle and is capped at DEPTH.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_wr/addr/wdata   register writes: 0 RATE, 1 DEPTH, 2 TARGET, 3 CTRL
//                       (CTRL bit0 start, bit1 abort)
//   sched_req, req_len  level request from the packet reader and its length
//   in_alf              downstream almost-full, blocks grants
//   sched_grant         one-cycle grant pulse
//   sent_start_flag     pulse in the first SEND cycle
//   sent_finish_flag    pulse in the single DONE cycle
//   sched_busy          state is not IDLE
//   sent_cnt            packets granted in the current or last run
//   timestamp           free-running time base
//   start_ts, finish_ts time of SEND entry / DONE entry
//
// Build option: define PGM_TB_STAT_EN to capture start_ts/finish_ts;
// otherwise both outputs are tied to 0.
// TOK_W must be at least 16 and at most 32, CNT_W at most 32.
module pgm_tb_sched #(
    parameter int unsigned TOK_W = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             sched_req,
    input  logic [15:0]      req_len,
    input  logic             in_alf,
    input  logic [31:0]      timestamp,
    output logic             sched_grant,
    output logic             sent_start_flag,
    output logic             sent_finish_flag,
    output logic             sched_busy,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [31:0]      start_ts,
    output logic [31:0]      finish_ts
);

    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    state_e             state_q, state_d;
    logic [15:0]        rate_q;
    logic [TOK_W-1:0]   depth_q;
    logic [CNT_W-1:0]   target_q;
    logic [TOK_W-1:0]   tokens_q, tokens_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic               start_q, start_d;

    logic               ctrl_wr, abort_req, start_req, grant_ok;
    logic [TOK_W-1:0]   len_ext;
    logic [TOK_W:0]     tok_sum;
    logic [TOK_W-1:0]   tok_cap;

    assign ctrl_wr   = cfg_wr && (cfg_addr == 2'd3);
    assign abort_req = ctrl_wr && cfg_wdata[1];
    // Abort wins over start when both bits are written together.
    assign start_req = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
    assign len_ext   = TOK_W'(req_len);

    // One extra bit so the refill never wraps before the DEPTH cap.
    assign tok_sum = {1'b0, tokens_q} + (TOK_W + 1)'(rate_q);
    assign tok_cap = (tok_sum > {1'b0, depth_q}) ? depth_q : tok_sum[TOK_W-1:0];

    // A grant already in flight blocks a back-to-back grant on the same request.
    assign grant_ok = (state_q == StSend) && sched_req && !in_alf &&
                      (tokens_q >= len_ext) && !grant_q && !abort_req;

    always_comb begin
        state_d  = state_q;
        tokens_d = tokens_q;
        cnt_d    = cnt_q;
        grant_d  = 1'b0;
        start_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                tokens_d = '0;
                if (start_req && (target_q != '0)) begin
                    state_d  = StSend;
                    tokens_d = depth_q;
                    cnt_d    = '0;
                    start_d  = 1'b1;
                end
            end
            StSend: begin
                grant_d  = grant_ok;
                tokens_d = tok_cap - (grant_ok ? len_ext : '0);
                if (grant_ok) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (abort_req || (grant_ok && (cnt_d == target_q))) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                tokens_d = '0;
                state_d  = StIdle;
            end
            default: begin
                tokens_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rate_q   <= '0;
            depth_q  <= '0;
            target_q <= '0;
            tokens_q <= '0;
            cnt_q    <= '0;
            grant_q  <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tokens_q <= tokens_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            start_q  <= start_d;
            // Parameter registers are frozen while a run is active.
            if (cfg_wr && (state_q == StIdle)) begin
                case (cfg_addr)
                    2'd0:    rate_q   <= cfg_wdata[15:0];
                    2'd1:    depth_q  <= TOK_W'(cfg_wdata);
                    2'd2:    target_q <= CNT_W'(cfg_wdata);
                    default: ;
                endcase
            end
        end
    end

    assign sched_grant      = grant_q;
    assign sent_start_flag  = start_q;
    assign sent_finish_flag = (state_q == StDone);
    assign sched_busy       = (state_q != StIdle);
    assign sent_cnt         = cnt_q;

`ifdef PGM_TB_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_ts  <= '0;
            finish_ts <= '0;
        end else begin
            if ((state_q == StIdle) && (state_d == StSend)) begin
                start_ts <= timestamp;
            end
            if ((state_q == StSend) && (state_d == StDone)) begin
                finish_ts <= timestamp;
            end
        end
    end
`else
    logic unused_timestamp;
    assign unused_timestamp = ^timestamp;
    assign start_ts  = '0;
    assign finish_ts = '0;
`endif

endmodule

// File: doc/pgm_tb_sched.md
PGM_TB_SCHED -- requirements
Module: pgm_tb_sched

Interface
REQ-001 Parameters SHALL be: TOK_W, default 32, token counter width in bytes; CNT_W, default 32, packet counter width.
REQ-002 clk  input  1  single clock; all logic SHALL be on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 cfg_wr  input  1  configuration write strobe.
REQ-005 cfg_addr  input  2  register select: 0 RATE (bytes/cycle, low 16 bits used), 1 DEPTH, 2 TARGET packet count, 3 CTRL (bit0 start, bit1 abort).
REQ-006 cfg_wdata  input  32  configuration write data.
REQ-007 sched_req  input  1  level request from the packet reader to send one stored packet; held until granted.
REQ-008 req_len  input  16  byte length of the requested packet; stable while sched_req is high.
REQ-009 in_alf  input  1  downstream almost-full.
REQ-010 sched_grant  output  1  one-cycle registered grant pulse.
REQ-011 sent_start_flag  output  1  one-cycle pulse at generation start.
REQ-012 sent_finish_flag  output  1  one-cycle pulse at generation end.
REQ-013 sched_busy  output  1  high when the state is not IDLE.
REQ-014 sent_cnt  output  CNT_W  packets granted in the current or last run.
REQ-015 timestamp  input  32  free-running timestamp.
REQ-016 start_ts, finish_ts  output  32 each  timestamps latched at start and finish.

Function
REQ-017 The FSM SHALL have the states IDLE, SEND and DONE.
REQ-018 IDLE->SEND on a CTRL write with bit0=1 when TARGET!=0; a start with TARGET=0, or a start outside IDLE, SHALL be ignored.
REQ-019 On entry to SEND: tokens<=DEPTH, sent_cnt<=0, and sent_start_flag high for the first SEND cycle only.
REQ-020 RATE, DEPTH and TARGET writes SHALL take effect only in IDLE; outside IDLE they SHALL be dropped.
REQ-021 Grant condition in cycle N: state==SEND, sched_req, !in_alf, tokens>=req_len, and sched_grant==0 in cycle N.
REQ-022 When the grant condition holds, sched_grant SHALL be high in cycle N+1.
REQ-023 Token update per edge in SEND SHALL be: tokens<=min(tokens+RATE, DEPTH) minus req_len if a grant is set at that edge.
REQ-024 The token addition SHALL use TOK_W+1 bits, so it never wraps.
REQ-025 sent_cnt SHALL increment at each grant edge.
REQ-026 A grant making sent_cnt==TARGET SHALL move the state to DONE at the same edge.
REQ-027 DONE SHALL last one cycle with sent_finish_flag=1, then return to IDLE.
REQ-028 A CTRL write with bit1=1 in SEND SHALL move to DONE with no further grants; a grant already registered completes.
REQ-029 Abort SHALL take priority over start in the same write.
REQ-030 In IDLE, tokens SHALL be held at 0 and sent_cnt SHALL hold its last value.
REQ-031 A req_len greater than DEPTH SHALL never be granted: the block stalls until abort.

Reset
REQ-032 With rst_n=0 at a clock edge: state IDLE; tokens 0; sent_cnt 0; RATE, DEPTH and TARGET 0; all outputs 0; start_ts and finish_ts 0.
REQ-033 A reset during SEND SHALL abandon the run with no finish pulse.

Configuration
REQ-034 The macro PGM_TB_STAT_EN SHALL control timestamp capture.
REQ-035 With PGM_TB_STAT_EN defined: start_ts<=timestamp on SEND entry; finish_ts<=timestamp on DONE entry.
REQ-036 Without PGM_TB_STAT_EN: start_ts and finish_ts SHALL be constant 0, and all other behaviour SHALL be identical.

Verification
REQ-037 RATE=8, DEPTH=64, TARGET=4, req_len=64, req held high -> 4 grants, the first one cycle after SEND entry, then spaced 9 cycles; one finish pulse; sent_cnt=4.
REQ-038 Same setup with in_alf=1 for 20 cycles after the first grant -> no grants while in_alf is high; next grant the cycle after in_alf falls; tokens capped at 64.
REQ-039 Abort written after 2 grants -> finish pulse next cycle, sent_cnt=2, sched_busy=0, no further grants.
REQ-040 RATE write during SEND, then start with TARGET=0 in IDLE -> rate unchanged, no start pulse, state stays IDLE.
REQ-041 req_len=100 with DEPTH=64 -> no grant for 200 cycles; abort recovers to IDLE.
REQ-042 PGM_TB_STAT_EN defined, timestamp=cycle count, start at 10 -> start_ts=10 and finish_ts equal to the DONE entry cycle; undefined -> both 0.
